// File: rtl/shift164_if.sv
// Byte-load handshake plus the serial lines that drive a downstream 74LS164.
// master = upstream byte producer, slave = shift164_driver.
interface shift164_if;
  logic [7:0] din;
  logic       load;
  logic       ready;
  logic       ds;
  logic       sck;
  logic       clr_n;
  logic       done;

  modport master (output din, load, input ready, ds, sck, clr_n, done);
  modport slave  (input din, load, output ready, ds, sck, clr_n, done);
endinterface

// File: rtl/shift164_driver.sv
// Serialises a byte MSB-first into a 74LS164 (DS to DSA/DSB, SCK to CP, CLR_n to MR_n).
// Define SHIFT164_CLEAR_EN to pulse CLR_n low for HALF_DIV cycles before every frame.
module shift164_driver #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic       cp_i,
  input  logic       mr_n_i,
  shift164_if.slave  bus,
  output logic [2:0] state_o
);

  // Handshake: a byte is taken on a cp_i edge where load=1 and ready=1; ready is high only in IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef SHIFT164_CLEAR_EN
    S_CLEAR = 3'd1,
`endif
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] HC_LAST = 8'(HALF_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sreg_q, sreg_d;
  logic       ready_q, ready_d;
  logic       ds_q, ds_d;
  logic       sck_q, sck_d;
  logic       clr_n_q, clr_n_d;
  logic       done_q, done_d;
  logic       phase_end;

  always_ff @(posedge cp_i or negedge mr_n_i) begin
    if (!mr_n_i) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      ready_q <= 1'b1;
      ds_q    <= 1'b0;
      sck_q   <= 1'b0;
      clr_n_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      ready_q <= ready_d;
      ds_q    <= ds_d;
      sck_q   <= sck_d;
      clr_n_q <= clr_n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    bcnt_d    = bcnt_q;
    sreg_d    = sreg_q;
    phase_end = (hcnt_q == HC_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.load && ready_q) begin
          sreg_d = bus.din;
          bcnt_d = '0;
          hcnt_d = '0;
`ifdef SHIFT164_CLEAR_EN
          state_d = S_CLEAR;
`else
          state_d = S_SETUP;
`endif
        end
      end
`ifdef SHIFT164_CLEAR_EN
      S_CLEAR: begin
        if (phase_end) begin
          hcnt_d  = '0;
          state_d = S_SETUP;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
`endif
      S_SETUP: begin
        if (phase_end) begin
          hcnt_d  = '0;
          state_d = S_HIGH;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          hcnt_d = '0;
          if (bcnt_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            sreg_d  = {sreg_q[6:0], 1'b0};
            bcnt_d  = bcnt_q + 3'd1;
            state_d = S_SETUP;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register lines up with the state it describes.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    sck_d   = (state_d == S_HIGH);
    done_d  = (state_d == S_DONE);
`ifdef SHIFT164_CLEAR_EN
    clr_n_d = (state_d != S_CLEAR);
`else
    clr_n_d = 1'b1;
`endif
    case (state_d)
      S_SETUP: ds_d = sreg_d[7];
      S_HIGH:  ds_d = ds_q;
      default: ds_d = 1'b0;
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.ds    = ds_q;
  assign bus.sck   = sck_q;
  assign bus.clr_n = clr_n_q;
  assign bus.done  = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_shift164_driver.sv
// Bench for shift164_driver: DUT0 with HALF_DIV=2, DUT1 with HALF_DIV=1, each feeding a 74LS164 model.
// Latency is counted as cp edges from the accepting edge to the first edge that samples DONE=1.
module tb_shift164_driver;

  localparam int H0 = 2;
  localparam int H1 = 1;

  logic       cp = 1'b0;
  logic       mr_n = 1'b0;
  logic [7:0] din_r [2];
  logic       load_r [2];
  logic [2:0] state0, state1;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  always #5 cp = ~cp;

  shift164_if bus0 ();
  shift164_if bus1 ();

  assign bus0.din  = din_r[0];
  assign bus0.load = load_r[0];
  assign bus1.din  = din_r[1];
  assign bus1.load = load_r[1];

  shift164_driver #(.HALF_DIV(H0)) dut0 (.cp_i(cp), .mr_n_i(mr_n), .bus(bus0), .state_o(state0));
  shift164_driver #(.HALF_DIV(H1)) dut1 (.cp_i(cp), .mr_n_i(mr_n), .bus(bus1), .state_o(state1));

  logic [1:0] sck_v, ds_v, done_v, ready_v, clr_v;
  assign sck_v   = {bus1.sck,   bus0.sck};
  assign ds_v    = {bus1.ds,    bus0.ds};
  assign done_v  = {bus1.done,  bus0.done};
  assign ready_v = {bus1.ready, bus0.ready};
  assign clr_v   = {bus1.clr_n, bus0.clr_n};

  // 74LS164 models: shift on SCK rise, Q0 takes DSA&DSB (both = DS), async clear.
  logic [7:0] q0, q1;
  always @(posedge bus0.sck or negedge bus0.clr_n)
    if (!bus0.clr_n) q0 <= 8'h00; else q0 <= {q0[6:0], bus0.ds};
  always @(posedge bus1.sck or negedge bus1.clr_n)
    if (!bus1.clr_n) q1 <= 8'h00; else q1 <= {q1[6:0], bus1.ds};

  int rise0 = 0, rise1 = 0, done0 = 0, done1 = 0;
  always @(posedge bus0.sck)  rise0 <= rise0 + 1;
  always @(posedge bus1.sck)  rise1 <= rise1 + 1;
  always @(posedge bus0.done) done0 <= done0 + 1;
  always @(posedge bus1.done) done1 <= done1 + 1;

  function automatic int hd(input int k);
    return (k == 0) ? H0 : H1;
  endfunction
  function automatic int rises(input int k);
    return (k == 0) ? rise0 : rise1;
  endfunction
  function automatic int dones(input int k);
    return (k == 0) ? done0 : done1;
  endfunction
  function automatic logic [7:0] qv(input int k);
    return (k == 0) ? q0 : q1;
  endfunction
  function automatic int exp_lat(input int k);
`ifdef SHIFT164_CLEAR_EN
    return 16 * hd(k) + 1 + hd(k);
`else
    return 16 * hd(k) + 1;
`endif
  endfunction
  function automatic int exp_space(input int k);
    return exp_lat(k) + 1;
  endfunction

  // Continuous protocol checker: DS stable while SCK high, every SCK phase inside a frame lasts HALF_DIV.
  logic [1:0] prev_sck = '0, prev_ds = '0, ph_valid = '0;
  int         ph_cnt [2];
  always @(negedge cp) begin
    for (int k = 0; k < 2; k++) begin
      if (!mr_n) begin
        ph_valid[k] <= 1'b0;
        ph_cnt[k]   <= 0;
      end else begin
        if (ds_v[k] !== prev_ds[k]) begin
          checks++;
          if (sck_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL ds_change_dut%0d: ds moved to %b with sck=%b, required sck=0", k, ds_v[k], sck_v[k]);
          end
        end
        if (sck_v[k] !== prev_sck[k]) begin
          if (ph_valid[k]) begin
            checks++;
            if (ph_cnt[k] != hd(k)) begin
              errors++;
              $display("FAIL phase_len_dut%0d: sck=%b phase lasted %0d, required %0d", k, prev_sck[k], ph_cnt[k], hd(k));
            end
          end
          ph_valid[k] <= !done_v[k];
          ph_cnt[k]   <= 1;
        end else begin
          ph_cnt[k] <= ph_cnt[k] + 1;
          if (done_v[k]) ph_valid[k] <= 1'b0;
        end
      end
      prev_sck[k] <= sck_v[k];
      prev_ds[k]  <= ds_v[k];
    end
  end

  // Driver: wait for READY, present a byte for one accepting edge; returns at the negedge after it.
  task automatic send_byte(input int k, input logic [7:0] b, input bit hold, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ready_v[k] && n < 1000) begin
      @(negedge cp);
      n++;
    end
    if (!ready_v[k]) return;
    din_r[k]  = b;
    load_r[k] = 1'b1;
    @(posedge cp);
    exp_q.push_back(b);
    @(negedge cp);
    if (!hold) load_r[k] = 1'b0;
    ok = 1'b1;
  endtask

  // Waits for DONE; with noise, throws ignored LOAD requests and DIN changes at the busy DUT.
  task automatic wait_done(input int k, input bit noise, output int lat, output bit ok);
    int m = 0;
    ok  = 1'b0;
    lat = 0;
    while (m < 4000) begin
      if (done_v[k]) begin
        lat = m + 1;
        ok  = 1'b1;
        break;
      end
      if (noise) begin
        if (m >= 1 && m <= 6) begin
          load_r[k] = 1'b1;
          din_r[k]  = 8'hFF;
        end else if (m > 6 && m <= 12 * hd(k)) begin
          load_r[k] = 1'($urandom_range(0, 1));
          din_r[k]  = 8'($urandom_range(0, 255));
        end else begin
          load_r[k] = 1'b0;
        end
      end
      @(negedge cp);
      m++;
    end
    if (noise) load_r[k] = 1'b0;
  endtask

  task automatic test_frame(input int k, input logic [7:0] b, input bit noise);
    bit ok;
    int lat, r;
    logic [7:0] exp;
    r = rises(k);
    send_byte(k, b, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_dut%0d: READY never seen, required within 1000 cycles", k);
      return;
    end
    checks++;
    if (ready_v[k] !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop_dut%0d: ready=%b after accept, required 0", k, ready_v[k]);
    end
    wait_done(k, noise, lat, ok);
    checks++;
    if (!ok || lat != exp_lat(k)) begin
      errors++;
      $display("FAIL latency_dut%0d: got %0d (seen=%b), required %0d", k, lat, ok, exp_lat(k));
    end
    @(negedge cp);
    checks++;
    if (done_v[k] !== 1'b0) begin
      errors++;
      $display("FAIL done_width_dut%0d: done=%b one cycle later, required 0", k, done_v[k]);
    end
    checks++;
    if (rises(k) - r != 8) begin
      errors++;
      $display("FAIL sck_edges_dut%0d: got %0d rising edges, required 8", k, rises(k) - r);
    end
    exp = exp_q.pop_front();
    checks++;
    if (qv(k) !== exp) begin
      errors++;
      $display("FAIL model_q_dut%0d: got %h, required %h", k, qv(k), exp);
    end
  endtask

  task automatic test_reset();
    din_r[0] = 8'h00; din_r[1] = 8'h00;
    load_r[0] = 1'b0; load_r[1] = 1'b0;
    mr_n = 1'b0;
    repeat (3) @(negedge cp);
    checks += 6;
    if (ready_v[0] !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", ready_v[0]); end
    if (sck_v[0]   !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b, required 0", sck_v[0]); end
    if (ds_v[0]    !== 1'b0) begin errors++; $display("FAIL rst_ds: got %b, required 0", ds_v[0]); end
    if (done_v[0]  !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done_v[0]); end
    if (clr_v[0]   !== 1'b0) begin errors++; $display("FAIL rst_clr_n: got %b, required 0", clr_v[0]); end
    if (q0 !== 8'h00) begin errors++; $display("FAIL rst_model_q: got %h, required 00", q0); end
    mr_n = 1'b1;
    @(negedge cp);
    checks++;
    if (clr_v !== 2'b11) begin
      errors++;
      $display("FAIL rst_clr_release: clr_n=%b after first edge, required 11", clr_v);
    end
  endtask

  task automatic test_basic();
    test_frame(0, 8'hA5, 1'b0);
  endtask

  task automatic test_ignore_load();
    test_frame(0, 8'h3C, 1'b1);
  endtask

  task automatic test_back_to_back();
    bit ok, seen_hi;
    int lat, cnt;
    logic [7:0] exp;
    send_byte(0, 8'h01, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_accept: READY never seen, required within 1000 cycles");
      load_r[0] = 1'b0;
      return;
    end
    din_r[0] = 8'h80;
    wait_done(0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != exp_lat(0)) begin
      errors++;
      $display("FAIL b2b_latency1: got %0d, required %0d", lat, exp_lat(0));
    end
    exp = exp_q.pop_front();
    checks++;
    if (q0 !== exp) begin errors++; $display("FAIL b2b_model_q1: got %h, required %h", q0, exp); end
    cnt = lat - 1;
    seen_hi = 1'b0;
    while (cnt < 4000) begin
      @(negedge cp);
      cnt++;
      if (seen_hi && !ready_v[0]) break;
      if (ready_v[0]) seen_hi = 1'b1;
    end
    exp_q.push_back(8'h80);
    load_r[0] = 1'b0;
    checks++;
    if (cnt != exp_space(0)) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between accepts, required %0d", cnt, exp_space(0));
    end
    wait_done(0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != exp_lat(0)) begin
      errors++;
      $display("FAIL b2b_latency2: got %0d, required %0d", lat, exp_lat(0));
    end
    exp = exp_q.pop_front();
    checks++;
    if (q0 !== exp) begin errors++; $display("FAIL b2b_model_q2: got %h, required %h", q0, exp); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int r, d, n;
    r = rise0;
    d = done0;
    send_byte(0, 8'hFF, 1'b0, ok);
    n = 0;
    while (rise0 - r < 5 && n < 400) begin
      @(negedge cp);
      n++;
    end
    checks++;
    if (sck_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_sck_high: sck=%b at bit 4 (ok=%b), required 1", sck_v[0], ok);
    end
    mr_n = 1'b0;
    #1;
    checks += 4;
    if (sck_v[0]   !== 1'b0) begin errors++; $display("FAIL mid_sck: got %b, required 0", sck_v[0]); end
    if (ds_v[0]    !== 1'b0) begin errors++; $display("FAIL mid_ds: got %b, required 0", ds_v[0]); end
    if (clr_v[0]   !== 1'b0) begin errors++; $display("FAIL mid_clr_n: got %b, required 0", clr_v[0]); end
    if (ready_v[0] !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", ready_v[0]); end
    repeat (2) @(negedge cp);
    mr_n = 1'b1;
    @(negedge cp);
    exp_q.delete();
    checks += 3;
    if (clr_v[0] !== 1'b1) begin errors++; $display("FAIL mid_clr_release: got %b, required 1", clr_v[0]); end
    if (q0 !== 8'h00) begin errors++; $display("FAIL mid_model_q: got %h, required 00", q0); end
    repeat (40) @(negedge cp);
    if (done0 != d) begin errors++; $display("FAIL mid_no_done: got %0d pulses, required 0", done0 - d); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge cp);
      test_frame(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_half_div1();
    test_frame(1, 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++)
      test_frame(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ignore_load();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_half_div1();
    repeat (4) @(negedge cp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift164_driver.md
SHIFT164_DRIVER -- requirements
Module: shift164_driver

Interface
REQ-001 Parameter HALF_DIV, default 2, number of CP cycles per SCK half-period; legal range 1..255.
REQ-002 CP  input  1  system clock; all state changes on rising edge.
REQ-003 MR_n  input  1  reset, asynchronous, active-low.
REQ-004 DIN  input  8  parallel byte to serialise.
REQ-005 LOAD  input  1  request; a byte is accepted on a CP edge where LOAD=1 and READY=1.
REQ-006 READY  output  1  high only in IDLE.
REQ-007 DS  output  1  serial data, wired to both DSA and DSB of the downstream 74LS164.
REQ-008 SCK  output  1  shift clock to downstream CP; registered, glitch-free.
REQ-009 CLR_n  output  1  clear to downstream MR_n; registered.
REQ-010 DONE  output  1  one-cycle pulse when the 8th bit has been clocked out.

Function
REQ-011 FSM states SHALL be IDLE, CLEAR, SETUP, HIGH, DONE; all outputs SHALL be registered.
REQ-012 IDLE: READY=1, SCK=0, DS=0, DONE=0; on accept, DIN captured into an 8-bit shift register, bit counter=0, half-period counter=0, next state CLEAR (macro set) else SETUP.
REQ-013 CLEAR: CLR_n=0 for HALF_DIV cycles, then CLR_n=1 and next state SETUP.
REQ-014 SETUP: SCK=0, DS=current MSB of shift register, held HALF_DIV cycles, then HIGH.
REQ-015 HIGH: SCK=1, DS unchanged, held HALF_DIV cycles; on exit, if bit counter=7 go DONE, else shift register left by 1, bit counter+1, go SETUP.
REQ-016 DONE: SCK=0, DONE=1 for exactly one cycle, READY=0, then IDLE.
REQ-017 Bit order SHALL be MSB first so downstream Q7..Q0 equals DIN[7:0] after the frame.
REQ-018 DS SHALL only change while SCK=0; SCK SHALL produce exactly 8 rising edges per frame.
REQ-019 Latency: DONE asserted 16*HALF_DIV+1 cycles after the accepting edge (+HALF_DIV with macro set).
REQ-020 LOAD while READY=0 SHALL be ignored with no effect on the frame in progress; DIN changes after accept SHALL not affect the frame.
REQ-021 Back-to-back: LOAD held high SHALL be accepted in the IDLE cycle following DONE; minimum frame spacing 16*HALF_DIV+2 cycles.
REQ-022 Half-period and bit counters SHALL be sized for HALF_DIV=255 with no wrap inside a phase.

Reset
REQ-023 MR_n=0 SHALL asynchronously force IDLE, SCK=0, DS=0, DONE=0, READY=1, CLR_n=0, counters and shift register to 0.
REQ-024 CLR_n SHALL return to 1 on the first CP rising edge after MR_n deasserts, clearing the downstream register with every local reset.
REQ-025 Reset mid-frame SHALL abort the frame; no DONE pulse; partial downstream contents cleared via CLR_n.

Configuration
REQ-026 Macro SHIFT164_CLEAR_EN defined: CLEAR state compiled in; downstream cleared before every frame.
REQ-027 Macro SHIFT164_CLEAR_EN undefined: CLEAR state absent; CLR_n low only during/after reset per REQ-024; IDLE goes directly to SETUP.

Verification (bench instantiates a 74LS164 behavioural model on DS/SCK/CLR_n, HALF_DIV=2)
REQ-028 Reset, then DIN=8'hA5, LOAD 1 cycle -> READY drops next cycle; DONE after 33 cycles (35 with macro); model Q7..Q0=8'hA5.
REQ-029 DIN=8'h3C accepted, then LOAD=1 with DIN=8'hFF during frame -> ignored; model holds 8'h3C; exactly 8 SCK rising edges counted.
REQ-030 LOAD held high, DIN 8'h01 then 8'h80 -> two frames, second accepted in IDLE cycle after first DONE; model ends at 8'h80 (macro set) / last 8 bits shifted (macro clear).
REQ-031 MR_n pulsed low at bit 4 of frame 8'hFF -> SCK/DS low immediately, no DONE, CLR_n low then high one edge after release; model reads 8'h00.
REQ-032 Checker over all runs: DS never changes while SCK=1; SCK high/low phases each exactly HALF_DIV cycles; repeat REQ-028 with HALF_DIV=1 -> DONE after 17 cycles (18 with macro).
